uart_receiver: RTL and testbench



---
 rtl/uart_receiver.sv | 188 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver
//   Serial receiver for 8-bit, LSB-first, no-parity frames with 1, 1.5 or 2 stop bits.
//   The line is resynchronised, a start edge is qualified at mid-bit, and data and stop
//   bits are sampled at mid-period. A good byte is handed over on a valid/ack handshake.
//
//   clk       in   1   system clock
//   resetn    in   1   asynchronous active-low reset
//   rec_en    in   1   receiver enable; low aborts any frame in progress
//   comp      in   16  bit period in clk cycles (values below 4 act as 4), latched per frame
//   stop_sel  in   2   0/3: 1 stop, 1: 1.5 stop, 2: 2 stop; latched per frame
//   uart_rx   in   1   asynchronous serial line, idle high
//   rx_data   out  8   last good byte
//   rx_valid  out  1   set when a good byte lands, cleared by rx_ack
//   rx_ack    in   1   consumer acknowledge
//   rx_err    out  1   one-cycle pulse on framing error
//   rx_ovr    out  1   one-cycle pulse when a byte lands over an unacknowledged one
//
//   state   | meaning
//   IDLE    | waiting for a falling edge on the synchronised line
//   START   | counting to mid start bit to reject glitches
//   RECEIVE | sampling eight data bits at mid-period
//   STOP    | checking the stop bit(s), then committing the byte

module uart_receiver (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rec_en,
    input  logic [15:0] comp,
    input  logic [1:0]  stop_sel,
    input  logic        uart_rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        rx_err,
    output logic        rx_ovr
);

    typedef enum logic [1:0] {IDLE, START, RECEIVE, STOP} state_t;

    state_t      state, state_nx;
    logic        sync1, rx_s;
    logic [15:0] comp_int, comp_c, comp_c_nx, half, stop_tc;
    logic [1:0]  stop_sel_int;
    logic [3:0]  bit_c, bit_c_nx;
    logic [7:0]  shift, shift_nx;
    logic        latch, err_nx, commit_nx, commit_q;
    // Cleared while a frame (or a break) holds the line low; a new start edge is
    // only accepted once the line has been seen high again.
    logic        armed;

    assign half = {1'b0, comp_int[15:1]};
    // bit_c 9 marks the second stop phase: a full bit for 2 stop, half a bit for 1.5.
    assign stop_tc = (bit_c == 4'd9 && stop_sel_int == 2'd1) ? half - 16'd1
                                                               : comp_int - 16'd1;

    always_comb begin
        state_nx  = state;
        comp_c_nx = comp_c;
        bit_c_nx  = bit_c;
        shift_nx  = shift;
        latch     = 1'b0;
        err_nx    = 1'b0;
        commit_nx = 1'b0;
        if (!rec_en) begin
            state_nx  = IDLE;
            comp_c_nx = 16'd0;
            bit_c_nx  = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s && armed) begin
                        state_nx  = START;
                        latch     = 1'b1;
                        comp_c_nx = 16'd0;
                        bit_c_nx  = 4'd0;
                    end
                end
                START: begin
                    if (comp_c == half - 16'd1) begin
                        comp_c_nx = 16'd0;
                        bit_c_nx  = 4'd0;
                        state_nx  = rx_s ? IDLE : RECEIVE;
                    end else begin
                        comp_c_nx = comp_c + 16'd1;
                    end
                end
                RECEIVE: begin
                    if (comp_c == comp_int - 16'd1) begin
                        shift_nx  = {rx_s, shift[7:1]};
                        comp_c_nx = 16'd0;
                        bit_c_nx  = bit_c + 4'd1;
                        if (bit_c == 4'd7) begin
                            state_nx = STOP;
                        end
                    end else begin
                        comp_c_nx = comp_c + 16'd1;
                    end
                end
                STOP: begin
                    if (comp_c == stop_tc) begin
                        comp_c_nx = 16'd0;
                        if (bit_c == 4'd8) begin
                            if (!rx_s) begin
                                err_nx   = 1'b1;
                                state_nx = IDLE;
                                bit_c_nx = 4'd0;
                            end else if (stop_sel_int == 2'd1 || stop_sel_int == 2'd2) begin
                                bit_c_nx = 4'd9;
                            end else begin
                                commit_nx = 1'b1;
                                state_nx  = IDLE;
                                bit_c_nx  = 4'd0;
                            end
                        end else begin
                            if (stop_sel_int == 2'd2 && !rx_s) begin
                                err_nx = 1'b1;
                            end else begin
                                commit_nx = 1'b1;
                            end
                            state_nx = IDLE;
                            bit_c_nx = 4'd0;
                        end
                    end else begin
                        comp_c_nx = comp_c + 16'd1;
                    end
                end
                default: begin
                    state_nx  = IDLE;
                    comp_c_nx = 16'd0;
                    bit_c_nx  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1        <= 1'b1;
            rx_s         <= 1'b1;
            armed        <= 1'b1;
            state        <= IDLE;
            comp_c       <= 16'd0;
            bit_c        <= 4'd0;
            shift        <= 8'd0;
            comp_int     <= 16'd0;
            stop_sel_int <= 2'd0;
            commit_q     <= 1'b0;
            rx_err       <= 1'b0;
        end else begin
            sync1    <= uart_rx;
            rx_s     <= sync1;
            state    <= state_nx;
            comp_c   <= comp_c_nx;
            bit_c    <= bit_c_nx;
            shift    <= shift_nx;
            commit_q <= commit_nx;
            rx_err   <= err_nx;
            if (latch) begin
                comp_int     <= (comp < 16'd4) ? 16'd4 : comp;
                stop_sel_int <= stop_sel;
            end
            if (rx_s) begin
                armed <= 1'b1;
            end else if (state != IDLE) begin
                armed <= 1'b0;
            end
        end
    end

    // Byte commit lands one cycle after the final stop sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
        end else begin
            rx_ovr <= 1'b0;
            if (commit_q) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
                rx_ovr   <= rx_valid && !rx_ack;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    logic        clk;
    logic        resetn;
    logic        rec_en;
    logic [15:0] comp;
    logic [1:0]  stop_sel;
    logic        uart_rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic        rx_err;
    logic        rx_ovr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_hi = 0;
    int ovr_hi = 0;
    int valid_cyc = -1;
    logic valid_q = 1'b0;
    int fall_cyc;
    int e0, o0;

    uart_receiver dut (
        .clk      (clk),
        .resetn   (resetn),
        .rec_en   (rec_en),
        .comp     (comp),
        .stop_sel (stop_sel),
        .uart_rx  (uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .rx_err   (rx_err),
        .rx_ovr   (rx_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (rx_err) err_hi = err_hi + 1;
        if (rx_ovr) ovr_hi = ovr_hi + 1;
        if (rx_valid && !valid_q) valid_cyc = cyc;
        valid_q = rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives start, 8 data bits LSB first, stop bit(s), then 3 bit periods of idle.
    task automatic send_frame(input logic [7:0] d, input logic s1, input logic s2,
                              input int nstop, input int per);
        fall_cyc = cyc;
        uart_rx = 1'b0;
        idle(per);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            idle(per);
        end
        uart_rx = s1;
        idle(per);
        if (nstop == 2) begin
            uart_rx = s2;
            idle(per);
        end
        uart_rx = 1'b1;
        idle(per * 3);
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        idle(1);
        rx_ack = 1'b0;
        idle(1);
    endtask

    initial begin
        resetn = 1'b0; rec_en = 1'b1; comp = 16'd16; stop_sel = 2'd0;
        uart_rx = 1'b1; rx_ack = 1'b0;
        idle(3);
        resetn = 1'b1;
        idle(5);
        chk("rst_data",  rx_data,  0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_err",   rx_err,   0);
        chk("rst_ovr",   rx_ovr,   0);

        // framing error: stop bit 0
        e0 = err_hi;
        send_frame(8'hA3, 1'b0, 1'b1, 1, 16);
        chk("ferr_pulse", err_hi - e0, 1);
        chk("ferr_valid", rx_valid, 0);
        chk("ferr_data",  rx_data,  0);

        // good byte, latency: D is 3 edges after line falls, valid at D+153
        e0 = err_hi;
        send_frame(8'h55, 1'b1, 1'b1, 1, 16);
        chk("b55_lat",   valid_cyc - fall_cyc, 156);
        chk("b55_data",  rx_data,  8'h55);
        chk("b55_valid", rx_valid, 1);
        chk("b55_err",   err_hi - e0, 0);
        ack();
        chk("ack_clr", rx_valid, 0);
        ack();
        chk("ack_idle", rx_valid, 0);

        // 3-cycle glitch
        e0 = err_hi;
        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        idle(40);
        chk("glitch_valid", rx_valid, 0);
        chk("glitch_err",   err_hi - e0, 0);

        // overrun
        o0 = ovr_hi;
        send_frame(8'h12, 1'b1, 1'b1, 1, 16);
        chk("ovr_first", ovr_hi - o0, 0);
        send_frame(8'h34, 1'b1, 1'b1, 1, 16);
        chk("ovr_pulse", ovr_hi - o0, 1);
        chk("ovr_data",  rx_data,  8'h34);
        chk("ovr_valid", rx_valid, 1);
        ack();

        // two stop bits
        stop_sel = 2'd2;
        e0 = err_hi;
        send_frame(8'hF0, 1'b1, 1'b0, 2, 16);
        chk("stop2_err",   err_hi - e0, 1);
        chk("stop2_valid", rx_valid, 0);
        e0 = err_hi;
        send_frame(8'hF0, 1'b1, 1'b1, 2, 16);
        chk("stop2_ok_valid", rx_valid, 1);
        chk("stop2_ok_data",  rx_data,  8'hF0);
        chk("stop2_ok_err",   err_hi - e0, 0);
        chk("stop2_lat", valid_cyc - fall_cyc, 172);
        ack();

        // 1.5 stop bits: commit half a bit after the first stop sample
        stop_sel = 2'd1;
        send_frame(8'hC3, 1'b1, 1'b1, 2, 16);
        chk("stop15_lat",  valid_cyc - fall_cyc, 164);
        chk("stop15_data", rx_data, 8'hC3);
        ack();

        // comp below 4 clamps to 4: half=2, valid at 3+2+9*4+1
        stop_sel = 2'd0;
        comp = 16'd2;
        send_frame(8'h5A, 1'b1, 1'b1, 1, 4);
        chk("clamp_lat",  valid_cyc - fall_cyc, 42);
        chk("clamp_data", rx_data, 8'h5A);
        ack();
        comp = 16'd16;

        // break: all-zero frame and line held low -> exactly one error
        e0 = err_hi;
        uart_rx = 1'b0;
        idle(16 * 10 + 200);
        uart_rx = 1'b1;
        idle(48);
        chk("break_err",   err_hi - e0, 1);
        chk("break_valid", rx_valid, 0);

        // rec_en dropped during bit 4 of 0x81
        e0 = err_hi; o0 = ovr_hi;
        fork
            send_frame(8'h81, 1'b1, 1'b1, 1, 16);
            begin
                idle(88);
                rec_en = 1'b0;
            end
        join
        rec_en = 1'b1;
        idle(20);
        chk("en_valid", rx_valid, 0);
        chk("en_err",   err_hi - e0, 0);
        chk("en_ovr",   ovr_hi - o0, 0);
        chk("en_data",  rx_data, 8'h5A);

        // resetn pulse mid-frame, held until the line is idle again
        fork
            send_frame(8'h81, 1'b1, 1'b1, 1, 16);
            begin
                idle(60);
                resetn = 1'b0;
            end
        join
        idle(1);
        chk("rstmid_data",  rx_data,  0);
        chk("rstmid_valid", rx_valid, 0);
        chk("rstmid_err",   rx_err,   0);
        chk("rstmid_ovr",   rx_ovr,   0);
        resetn = 1'b1;
        idle(5);

        // recovery after reset
        send_frame(8'h3C, 1'b1, 1'b1, 1, 16);
        chk("recov_lat",  valid_cyc - fall_cyc, 156);
        chk("recov_data", rx_data, 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
